// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Contains the FSM state encoding and the counter-width helper.
package serial_adder_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  typedef enum logic {
    IDLE = STATE_IDLE,
    RUN  = STATE_RUN
  } state_t;

  // Number of bits needed to encode values 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_n_full_adder_cell.sv
// Combinational one-bit full adder.
// The serial adder reuses this cell once per clock.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// {cout,sum} = a + b + cin is presented with a one-cycle done pulse.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_sh_s;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             load_s;
  logic             step_s;
  logic             finish_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  full_adder_cell u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Next sum shift value: cell sum bit enters at the MSB (also correct for WIDTH=1).
  always_comb begin
    sum_sh_s = sum_sh_r >> 1'b1;
    sum_sh_s[WIDTH-1] = fa_sum_s;
  end

  // Next-state and step control.
  always_comb begin
    state_n  = state_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_n  = IDLE;
          finish_s = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      carry_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == RUN);
      done_r  <= finish_s;
      if (load_s) begin
        a_sh_r   <= a;
        b_sh_r   <= b;
        sum_sh_r <= {WIDTH{1'b0}};
        carry_r  <= cin;
        cnt_r    <= {CNT_W{1'b0}};
      end else if (step_s) begin
        a_sh_r   <= a_sh_r >> 1'b1;
        b_sh_r   <= b_sh_r >> 1'b1;
        sum_sh_r <= sum_sh_s;
        carry_r  <= fa_cout_s;
        cnt_r    <= cnt_r + CNT_ONE;
      end
      // Only the completion edge updates the visible result.
      if (finish_s) begin
        sum_r  <= sum_sh_s;
        cout_r <= fa_cout_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n at WIDTH=8, WIDTH=1 and WIDTH=13.
// Stimulus pushes expected results; negedge monitors pop and compare on done.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  logic [8:0]  exp8_q[$];
  logic [1:0]  exp1_q[$];
  logic [13:0] exp13_q[$];
  logic [8:0]  last8 = 9'h000;

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder_n #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  serial_adder_n #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // Monitor for WIDTH=8: result on done, hold between completions.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      last8 = 9'h000;
    end else if (done8) begin
      tests++;
      if (exp8_q.size() == 0) begin
        failed++;
        $display("FAIL w8_unexpected_done: got 0x%0h, required no done", {cout8, sum8});
      end else begin
        e = exp8_q.pop_front();
        if ({cout8, sum8} !== e) begin
          failed++;
          $display("FAIL w8_result: got 0x%0h, required 0x%0h", {cout8, sum8}, e);
        end
      end
      last8 = {cout8, sum8};
    end else begin
      tests++;
      if ({cout8, sum8} !== last8) begin
        failed++;
        $display("FAIL w8_hold: got 0x%0h, required 0x%0h", {cout8, sum8}, last8);
      end
    end
  end

  // Monitor for WIDTH=1.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && done1) begin
      tests++;
      if (exp1_q.size() == 0) begin
        failed++;
        $display("FAIL w1_unexpected_done: got 0x%0h, required no done", {cout1, sum1});
      end else begin
        e = exp1_q.pop_front();
        if ({cout1, sum1} !== e) begin
          failed++;
          $display("FAIL w1_result: got 0x%0h, required 0x%0h", {cout1, sum1}, e);
        end
      end
    end
  end

  // Monitor for WIDTH=13.
  always @(negedge clk) begin
    logic [13:0] e;
    if (rst_n && done13) begin
      tests++;
      if (exp13_q.size() == 0) begin
        failed++;
        $display("FAIL w13_unexpected_done: got 0x%0h, required no done", {cout13, sum13});
      end else begin
        e = exp13_q.pop_front();
        if ({cout13, sum13} !== e) begin
          failed++;
          $display("FAIL w13_result: got 0x%0h, required 0x%0h", {cout13, sum13}, e);
        end
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] e);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    exp8_q.push_back(e);
    #1 start8 = 1'b0;
  endtask

  // Called #1 after the accepting edge; k = edges until done, bc = busy samples.
  task automatic wait_done8(output int k, output int bc);
    k = 0; bc = 0;
    if (busy8) bc++;
    while (k < 40) begin
      @(posedge clk); #1; k++;
      if (done8) break;
      if (busy8) bc++;
    end
    check("w8_done_seen", 32'(done8), 32'd1);
  endtask

  initial begin
    int k, bc;
    logic [12:0] ra, rb;
    logic rc;
    rst_n = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    start13 = 1'b0; a13 = 13'h0; b13 = 13'h0; cin13 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum", 32'(sum8), 32'd0);
    check("reset_cout", 32'(cout8), 32'd0);

    // Basic add with latency and busy-length checks.
    issue8(8'h00, 8'h00, 1'b0, 9'h000);
    wait_done8(k, bc);
    check("w8_latency", 32'(k), 32'd8);
    check("w8_busy_cycles", 32'(bc), 32'd8);
    check("w8_busy_low_at_done", 32'(busy8), 32'd0);

    issue8(8'hFF, 8'h01, 1'b0, 9'h100);
    wait_done8(k, bc);
    issue8(8'hA5, 8'h5A, 1'b1, 9'h100);
    wait_done8(k, bc);
    repeat (2) @(posedge clk);

    // Start pulsed mid-RUN must be ignored.
    issue8(8'h3C, 8'h42, 1'b0, 9'h07E);
    repeat (3) @(posedge clk);
    #1 a8 = 8'h11; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    wait_done8(k, bc);
    repeat (12) @(posedge clk);

    // Back-to-back: new start issued in the done cycle.
    issue8(8'h80, 8'h81, 1'b0, 9'h101);
    wait_done8(k, bc);
    issue8(8'h10, 8'h20, 1'b0, 9'h030);
    wait_done8(k, bc);
    check("w8_b2b_latency", 32'(k), 32'd8);
    repeat (2) @(posedge clk);

    // Reset while cnt==3 discards the operation.
    issue8(8'h55, 8'h33, 1'b0, 9'h088);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp8_q.delete();
    #1;
    check("rst_mid_busy", 32'(busy8), 32'd0);
    check("rst_mid_done", 32'(done8), 32'd0);
    check("rst_mid_sum", 32'(sum8), 32'd0);
    check("rst_mid_cout", 32'(cout8), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue8(8'h55, 8'h33, 1'b0, 9'h088);
    wait_done8(k, bc);
    check("w8_post_reset_latency", 32'(k), 32'd8);

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk);
      exp1_q.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      #1 start1 = 1'b0;
      k = 0;
      while (k < 10) begin
        @(posedge clk); #1; k++;
        if (done1) break;
      end
      check("w1_latency", 32'(k), 32'd1);
      @(posedge clk); #1;
    end

    // WIDTH=13 random regression against a 14-bit model.
    for (int n = 0; n < 1000; n++) begin
      ra = 13'($urandom); rb = 13'($urandom); rc = 1'($urandom);
      a13 = ra; b13 = rb; cin13 = rc; start13 = 1'b1;
      @(posedge clk);
      exp13_q.push_back({1'b0, ra} + {1'b0, rb} + 14'(rc));
      #1 start13 = 1'b0;
      k = 0;
      while (k < 40) begin
        @(posedge clk); #1; k++;
        if (done13) break;
      end
      if (k >= 40) check("w13_done_timeout", 32'(done13), 32'd1);
    end

    repeat (4) @(posedge clk);
    check("w8_queue_drained", 32'(exp8_q.size()), 32'd0);
    check("w1_queue_drained", 32'(exp1_q.size()), 32'd0);
    check("w13_queue_drained", 32'(exp13_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
